// File: rtl/x68k_ldr_pkg.sv
// Shared types and constants for the X68K ROM/IPL loader sequencer.
package x68k_ldr_pkg;

  localparam int LDR_TIMEOUT_W = 12;
  localparam int LDR_DATA_W    = 8;
  localparam int LDR_ADDR_W    = 20;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } ldr_state_t;

  typedef struct packed {
    logic [LDR_ADDR_W-1:0] addr;
    logic [LDR_DATA_W-1:0] data;
  } ldr_entry_t;

  // The loader owns the core memory bus while bytes may still be in the pipe.
  function automatic logic is_active(input ldr_state_t s);
    return (s == LOAD) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/ldr_sequencer_if.sv
// HPS ioctl download side and X68K loader port side of the loader sequencer.
interface ldr_sequencer_if
  import x68k_ldr_pkg::*;
#(
  parameter int ADDR_W = 20
);

  logic                  ioctl_download;
  logic [7:0]            ioctl_index;
  logic                  ioctl_wr;
  logic [24:0]           ioctl_addr;
  logic [LDR_DATA_W-1:0] ioctl_dout;
  logic                  ioctl_wait;

  logic                  ldr_aen;
  logic [ADDR_W-1:0]     ldr_addr;
  logic [LDR_DATA_W-1:0] ldr_wdat;
  logic                  ldr_wr;
  logic                  ldr_ack;

  logic                  ldr_done;
  logic                  core_rstn;
  logic                  err_timeout;
  logic                  err_range;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    output ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_wr,
    output ldr_done, core_rstn, err_timeout, err_range
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ldr_ack,
    input  ioctl_wait, ldr_aen, ldr_addr, ldr_wdat, ldr_wr,
    input  ldr_done, core_rstn, err_timeout, err_range
  );

endinterface

// File: rtl/ldr_fifo.sv
// Synchronous byte-entry FIFO with a one-entry skid slot that absorbs a strobe
// arriving while the FIFO proper is full.
module ldr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 2)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic [CW-1:0]    level_nxt_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             skid_vld_q, skid_vld_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             do_pop, space, wr_en;
  logic [WIDTH-1:0] wr_data;

  always_comb begin
    do_pop     = pop_i && (cnt_q != '0);
    space      = (cnt_q != DEPTH_C) || do_pop;
    wr_en      = 1'b0;
    wr_data    = push_data_i;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;
    // The skid entry is older than any new strobe, so it always enters first.
    if (skid_vld_q) begin
      if (space) begin
        wr_en      = 1'b1;
        wr_data    = skid_q;
        skid_vld_d = push_i;
        if (push_i) skid_d = push_data_i;
      end
    end else if (push_i) begin
      if (space) begin
        wr_en = 1'b1;
      end else begin
        skid_vld_d = 1'b1;
        skid_d     = push_data_i;
      end
    end
    cnt_d    = cnt_q + CW'(wr_en) - CW'(do_pop);
    wr_ptr_d = wr_en  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    skid_q <= skid_d;
  end

  assign head_o      = mem_q[rd_ptr_q];
  assign empty_o     = (cnt_q == '0);
  assign level_nxt_o = cnt_d + CW'(skid_vld_d);

endmodule

// File: rtl/ldr_sequencer.sv
// Buffers HPS ioctl download bytes and replays them onto the X68K loader port
// through the ldr_wr/ldr_ack handshake, holding the core in reset until done.
module ldr_sequencer
  import x68k_ldr_pkg::*;
#(
  parameter int         ADDR_W      = 20,
  parameter int         FIFO_DEPTH  = 4,
  parameter logic [7:0] LOAD_INDEX  = 8'h00,
  parameter int         ACK_TIMEOUT = 4095
) (
  input  logic     clk_sys,
  input  logic     reset,
  ldr_sequencer_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 2);
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);
  localparam logic [LDR_TIMEOUT_W-1:0] TO_LIM = LDR_TIMEOUT_W'(ACK_TIMEOUT);

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [LDR_DATA_W-1:0] data;
  } entry_t;
  localparam int EW = $bits(entry_t);

  ldr_state_t state_q, state_d;

  logic                     dl_q, ack_q;
  logic                     wr_q, wr_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [LDR_DATA_W-1:0]    wdat_q, wdat_d;
  logic [LDR_TIMEOUT_W-1:0] to_q, to_d;
  logic                     done_q, done_d;
  logic                     rstn_q;
  logic                     err_to_q, err_to_d;
  logic                     err_rng_q, err_rng_d;
  logic                     wait_q, wait_d;

  logic          dl_rise, dl_fall, idx_match, in_range, strobe_ok, ack_rise;
  logic          push, pop, fifo_empty;
  entry_t        push_entry, head;
  logic [EW-1:0] head_raw;
  logic [CW-1:0] level_nxt;

  assign dl_rise   = bus.ioctl_download & ~dl_q;
  assign dl_fall   = ~bus.ioctl_download & dl_q;
  assign idx_match = (bus.ioctl_index == LOAD_INDEX);
  assign in_range  = ~|bus.ioctl_addr[24:ADDR_W];
  assign ack_rise  = bus.ldr_ack & ~ack_q;

  // dl_q keeps a strobe that coincides with the falling download edge acceptable.
  assign strobe_ok  = bus.ioctl_wr & (bus.ioctl_download | dl_q) & idx_match & (state_q == LOAD);
  assign push       = strobe_ok & in_range;
  assign push_entry = '{addr: bus.ioctl_addr[ADDR_W-1:0], data: bus.ioctl_dout};
  assign pop        = is_active(state_q) & ~wr_q & ~fifo_empty;
  assign head       = entry_t'(head_raw);

  ldr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i       (clk_sys),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head_raw),
    .empty_o     (fifo_empty),
    .level_nxt_o (level_nxt)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (dl_rise && idx_match && !done_q) state_d = LOAD;
      LOAD:    if (dl_fall) state_d = DRAIN;
      DRAIN:   if (fifo_empty && !wr_q) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdat_d    = wdat_q;
    to_d      = '0;
    err_to_d  = err_to_q;
    err_rng_d = err_rng_q | (strobe_ok & ~in_range);
    done_d    = done_q | ((state_q == DRAIN) && (state_d == DONE));
    wait_d    = is_active(state_d) && (level_nxt >= WAIT_LVL);
    // A timed-out write is dropped rather than retried so the download keeps moving.
    if (wr_q) begin
      if (ack_rise) begin
        wr_d = 1'b0;
      end else if (to_q == TO_LIM) begin
        wr_d     = 1'b0;
        err_to_d = 1'b1;
      end else begin
        to_d = to_q + LDR_TIMEOUT_W'(1);
      end
    end else if (pop) begin
      wr_d   = 1'b1;
      addr_d = head.addr;
      wdat_d = head.data;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_q      <= 1'b0;
      ack_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdat_q    <= '0;
      to_q      <= '0;
      done_q    <= 1'b0;
      rstn_q    <= 1'b0;
      err_to_q  <= 1'b0;
      err_rng_q <= 1'b0;
      wait_q    <= 1'b0;
    end else begin
      dl_q      <= bus.ioctl_download;
      ack_q     <= bus.ldr_ack;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdat_q    <= wdat_d;
      to_q      <= to_d;
      done_q    <= done_d;
      rstn_q    <= done_q;
      err_to_q  <= err_to_d;
      err_rng_q <= err_rng_d;
      wait_q    <= wait_d;
    end
  end

  assign bus.ioctl_wait  = wait_q;
  assign bus.ldr_aen     = is_active(state_q);
  assign bus.ldr_addr    = addr_q;
  assign bus.ldr_wdat    = wdat_q;
  assign bus.ldr_wr      = wr_q;
  assign bus.ldr_done    = done_q;
  assign bus.core_rstn   = rstn_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_range   = err_rng_q;

endmodule

// File: tb/tb_ldr_sequencer.sv
// Self-checking bench for ldr_sequencer: random download bytes, an ack responder,
// and a queue-based model of which bytes must reach the loader port, in order.
module tb_ldr_sequencer;

  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ldr_sequencer_if #(.ADDR_W(AW)) bus ();

  ldr_sequencer #(
    .ADDR_W      (AW),
    .FIFO_DEPTH  (4),
    .LOAD_INDEX  (8'h00),
    .ACK_TIMEOUT (4095)
  ) dut (
    .clk_sys (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [24:0]   stim_addr[$];
  logic [7:0]    stim_dat[$];
  logic [AW+7:0] exp_q[$];
  logic [AW+7:0] obs_q[$];
  int n_acc = 0;
  int n_wr = 0;
  int stab_err = 0;
  int min_gap = 1000;
  int max_hi = 0;
  int cyc = 0;
  int last_fall = -1;
  int last_rise = 0;
  logic          wr_prev = 1'b0;
  logic [AW+7:0] aw_prev = '0;

  bit ack_en = 1'b1;
  int ack_delay = 2;
  int ack_skip = -1;
  int resp_cnt = 0;

  // Loader port monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (bus.ldr_wr && !wr_prev) begin
      obs_q.push_back({bus.ldr_addr, bus.ldr_wdat});
      n_wr++;
      last_rise = cyc;
      if (last_fall >= 0 && (cyc - last_fall) < min_gap) min_gap = cyc - last_fall;
    end else if (bus.ldr_wr && wr_prev && ({bus.ldr_addr, bus.ldr_wdat} != aw_prev)) begin
      stab_err++;
    end
    if (!bus.ldr_wr && wr_prev) begin
      last_fall = cyc;
      if ((cyc - last_rise) > max_hi) max_hi = cyc - last_rise;
    end
    wr_prev = bus.ldr_wr;
    aw_prev = {bus.ldr_addr, bus.ldr_wdat};
  end

  // Core-side ack responder: one-cycle ack pulse ack_delay cycles into each write.
  initial begin
    bus.ldr_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ldr_wr === 1'b1) begin
        int this_idx;
        this_idx = resp_cnt;
        resp_cnt++;
        if (ack_en && this_idx != ack_skip) begin
          repeat (ack_delay - 1) @(negedge clk);
          bus.ldr_ack = 1'b1;
          @(negedge clk);
          bus.ldr_ack = 1'b0;
        end
        for (int g = 0; g < 6000 && bus.ldr_wr === 1'b1; g++) @(negedge clk);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    n_acc = 0;
    n_wr = 0;
    stab_err = 0;
    min_gap = 1000;
    max_hi = 0;
    last_fall = -1;
  endtask

  task automatic make_stim(input int n, input logic [24:0] base);
    stim_addr.delete();
    stim_dat.delete();
    for (int i = 0; i < n; i++) begin
      stim_addr.push_back(base + 25'(i));
      stim_dat.push_back(8'($urandom));
    end
  endtask

  // HPS model: strobes each stimulus byte, honouring ioctl_wait. Bytes the loader
  // should accept (right index, ready to load, in range) go into exp_q.
  task automatic download(input logic [7:0] idx, input bit acc, input int max_gap,
                          input bit chk_wait, input bit fall_with_last);
    int g;
    int gap;
    logic exp_w;
    bit stuck;
    stuck = 1'b0;
    @(negedge clk);
    bus.ioctl_index = idx;
    bus.ioctl_download = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.ldr_aen !== acc) begin
      errors++;
      $display("FAIL aen_during_load: got %b want %b", bus.ldr_aen, acc);
    end
    for (int i = 0; i < stim_addr.size() && !stuck; i++) begin
      g = 0;
      forever begin
        if (chk_wait) begin
          exp_w = ((n_acc - n_wr) >= 3);
          checks++;
          if (bus.ioctl_wait !== exp_w) begin
            errors++;
            $display("FAIL ioctl_wait_level: got %b want %b (buffered %0d)", bus.ioctl_wait, exp_w, n_acc - n_wr);
          end
        end
        if (bus.ioctl_wait !== 1'b1) break;
        bus.ioctl_wr = 1'b0;
        g++;
        if (g > 10000) begin
          errors++;
          $display("FAIL ioctl_wait_stuck: got 1 want 0 within 10000 cycles");
          stuck = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!stuck) begin
        bus.ioctl_wr = 1'b1;
        bus.ioctl_addr = stim_addr[i];
        bus.ioctl_dout = stim_dat[i];
        if (fall_with_last && i == stim_addr.size() - 1) bus.ioctl_download = 1'b0;
        if (acc && stim_addr[i] < 25'h100000) begin
          exp_q.push_back({stim_addr[i][AW-1:0], stim_dat[i]});
          n_acc++;
        end
        @(negedge clk);
        gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
        if (gap > 0) begin
          bus.ioctl_wr = 1'b0;
          repeat (gap) @(negedge clk);
        end
      end
    end
    bus.ioctl_wr = 1'b0;
    bus.ioctl_download = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (bus.ldr_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.ioctl_wait, bus.ldr_aen, bus.ldr_wr, bus.ldr_done, bus.core_rstn} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.ioctl_wait, bus.ldr_aen, bus.ldr_wr, bus.ldr_done, bus.core_rstn});
    end
    checks++;
    if ({bus.ldr_addr, bus.ldr_wdat} !== '0) begin
      errors++;
      $display("FAIL reset_addr_data: got %h want 0", {bus.ldr_addr, bus.ldr_wdat});
    end
    checks++;
    if ({bus.err_timeout, bus.err_range} !== 2'b00) begin
      errors++;
      $display("FAIL reset_errs: got %b want 00", {bus.err_timeout, bus.err_range});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ldr_aen !== 1'b0) begin
      errors++;
      $display("FAIL idle_aen: got %b want 0", bus.ldr_aen);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    clear_obs();
    ack_en = 1'b1;
    ack_delay = 2;
    make_stim(16, 25'h0);
    download(8'h00, 1'b1, 3, 1'b0, 1'b1);
    wait_done(2000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL basic_done: got 0 want 1");
    end
    checks++;
    if (bus.core_rstn !== 1'b0) begin
      errors++;
      $display("FAIL basic_rstn_lag: got %b want 0", bus.core_rstn);
    end
    @(negedge clk);
    checks++;
    if (bus.core_rstn !== 1'b1) begin
      errors++;
      $display("FAIL basic_rstn: got %b want 1", bus.core_rstn);
    end
    checks++;
    if (obs_q.size() != 16 || exp_q.size() != 16) begin
      errors++;
      $display("FAIL basic_count: got %0d want %0d", obs_q.size(), 16);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    checks++;
    if (stab_err != 0 || bus.ldr_aen !== 1'b0 || {bus.err_timeout, bus.err_range} !== 2'b00) begin
      errors++;
      $display("FAIL basic_misc: got stab=%0d aen=%b errs=%b want 0 0 00",
               stab_err, bus.ldr_aen, {bus.err_timeout, bus.err_range});
    end
    // A later download after completion must be ignored.
    clear_obs();
    make_stim(4, 25'h40);
    download(8'h00, 1'b0, 1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.ioctl_wait !== 1'b0 || bus.ldr_done !== 1'b1) begin
      errors++;
      $display("FAIL done_ignores: got writes=%0d wait=%b done=%b want 0 0 1",
               obs_q.size(), bus.ioctl_wait, bus.ldr_done);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit incr;
    do_reset();
    clear_obs();
    ack_delay = 20;
    make_stim(12, 25'($urandom_range(0, 4000)));
    download(8'h00, 1'b1, 0, 1'b1, 1'b0);
    wait_done(3000, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL bp_count: got done=%b writes=%0d want 1 %0d", ok, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL bp_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    incr = 1'b1;
    for (int i = 1; i < obs_q.size(); i++)
      if (obs_q[i][AW+7:8] <= obs_q[i-1][AW+7:8]) incr = 1'b0;
    checks++;
    if (!incr) begin
      errors++;
      $display("FAIL bp_addr_increasing: got 0 want 1");
    end
    checks++;
    if (min_gap != 1 || stab_err != 0) begin
      errors++;
      $display("FAIL bp_wr_gap: got gap=%0d stab=%0d want 1 0", min_gap, stab_err);
    end
    ack_delay = 2;
  endtask

  task automatic test_wrong_index();
    do_reset();
    clear_obs();
    make_stim(6, 25'h80);
    download(8'h01, 1'b0, 2, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || bus.ldr_aen !== 1'b0 || bus.ldr_done !== 1'b0 || bus.ioctl_wait !== 1'b0) begin
      errors++;
      $display("FAIL wrong_index: got writes=%0d aen=%b done=%b wait=%b want 0 0 0 0",
               obs_q.size(), bus.ldr_aen, bus.ldr_done, bus.ioctl_wait);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    clear_obs();
    ack_delay = 2;
    ack_skip = resp_cnt + 5;
    make_stim(10, 25'h200);
    download(8'h00, 1'b1, 1, 1'b0, 1'b0);
    wait_done(12000, ok);
    ack_skip = -1;
    checks++;
    if (!ok || bus.err_timeout !== 1'b1 || bus.err_range !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flags: got done=%b to=%b rng=%b want 1 1 0", ok, bus.err_timeout, bus.err_range);
    end
    checks++;
    if (max_hi < 4095 || max_hi > 4097) begin
      errors++;
      $display("FAIL timeout_length: got %0d want 4095..4097", max_hi);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL timeout_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL timeout_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_range();
    bit ok;
    do_reset();
    clear_obs();
    ack_delay = 1;
    stim_addr = '{25'h10, 25'h11, 25'h100000, 25'h12, 25'h1FFFFF, 25'hFFFFF};
    stim_dat.delete();
    for (int i = 0; i < 6; i++) stim_dat.push_back(8'($urandom));
    download(8'h00, 1'b1, 1, 1'b0, 1'b0);
    wait_done(2000, ok);
    checks++;
    if (!ok || bus.err_range !== 1'b1 || bus.err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL range_flags: got done=%b rng=%b to=%b want 1 1 0", ok, bus.err_range, bus.err_timeout);
    end
    checks++;
    if (obs_q.size() != 4 || exp_q.size() != 4) begin
      errors++;
      $display("FAIL range_count: got %0d want 4", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL range_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
    ack_delay = 2;
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    do_reset();
    clear_obs();
    ack_en = 1'b0;
    make_stim(3, 25'h300);
    download(8'h00, 1'b1, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ldr_wr !== 1'b1 || bus.ldr_aen !== 1'b1) begin
      errors++;
      $display("FAIL drain_pre: got wr=%b aen=%b want 1 1", bus.ldr_wr, bus.ldr_aen);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.ldr_wr, bus.ldr_aen, bus.ldr_done} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset: got %b want 000", {bus.ldr_wr, bus.ldr_aen, bus.ldr_done});
    end
    @(negedge clk);
    rst = 1'b0;
    ack_en = 1'b1;
    ack_delay = 2;
    repeat (2) @(negedge clk);
    clear_obs();
    make_stim(5, 25'h400);
    download(8'h00, 1'b1, 2, 1'b0, 1'b0);
    wait_done(2000, ok);
    checks++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL reload_count: got done=%b writes=%0d want 1 %0d", ok, obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL reload_write[%0d]: got %h want %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'h00;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_wrong_index();
    test_timeout();
    test_range();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
